// File: rtl/pill_multi_slot_scheduler.sv
// pill_multi_slot_scheduler
//   Holds N_SLOTS programmable BCD dose times, compares them with the running
//   BCD clock and serves matching slots one at a time through a reminder/alarm
//   FSM with timed escalation, queued matches and a saturating missed-dose count.
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   time_now            current time, BCD {H1,H0,M1,M0}
//   cfg_we/slot/time/en slot programming strobe and payload
//   taken               pill-taken sensor (rising edge used)
//   its_time, alarm     reminder / escalated alarm indicators
//   buzzer              buzzer drive (toggling in REMIND, steady in ALARM)
//   active_slot         slot being served
//   wait_min            minute ticks since the served dose time
//   pending             queued slot matches
//   miss_count          saturating missed-dose counter
//   dose_ok, dose_miss  one-cycle outcome pulses
//   cfg_err             one-cycle pulse for a rejected config write
module pill_multi_slot_scheduler #(
  parameter int unsigned N_SLOTS   = 4,
  parameter int unsigned WARN_MIN  = 5,
  parameter int unsigned GRACE_MIN = 30,
  parameter int unsigned BEEP_DIV  = 25000000,
  parameter int unsigned MISS_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         time_now,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_slot,
  input  logic [15:0]         cfg_time,
  input  logic                cfg_en,
  input  logic                taken,
  output logic                its_time,
  output logic                alarm,
  output logic                buzzer,
  output logic [2:0]          active_slot,
  output logic [5:0]          wait_min,
  output logic [N_SLOTS-1:0]  pending,
  output logic [MISS_W-1:0]   miss_count,
  output logic                dose_ok,
  output logic                dose_miss,
  output logic                cfg_err
);

  localparam int unsigned BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REMIND = 2'd1,
    ALARM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [15:0]        slot_time [N_SLOTS];
  logic [N_SLOTS-1:0] slot_en;

  logic [15:0]        time_prev;
  logic               min_tick;
  logic               taken_prev;
  logic [BEEP_W-1:0]  beep_cnt, beep_cnt_n;

  logic [2:0]         active_n;
  logic [5:0]         wait_n, wm_inc;
  logic [N_SLOTS-1:0] pending_n, pend_eff, match_vec, sel_mask, cfg_mask;
  logic [2:0]         sel;
  logic [MISS_W-1:0]  miss_n;
  logic               its_time_n, alarm_n, buzzer_n, dose_ok_n, dose_miss_n;
  logic               taken_rise_c, cfg_accept_c, bcd_ok_c, slot_ok_c, serving_c;

  // Config write validation: slot in range and a legal 00:00..23:59 BCD time.
  always_comb begin
    slot_ok_c = (4'(cfg_slot) < 4'(N_SLOTS));
    bcd_ok_c  = (cfg_time[15:12] <= 4'd2) && (cfg_time[11:8] <= 4'd9) &&
                (cfg_time[7:4]   <= 4'd5) && (cfg_time[3:0]  <= 4'd9) &&
                !((cfg_time[15:12] == 4'd2) && (cfg_time[11:8] > 4'd3));
    cfg_accept_c = cfg_we && slot_ok_c && bcd_ok_c;
  end

  // Slot storage; index compared per slot so cfg_slot never addresses past N_SLOTS.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        slot_time[i] <= 16'h0000;
      end
      slot_en <= '0;
    end else if (cfg_accept_c) begin
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        if (cfg_slot == 3'(i)) begin
          slot_time[i] <= cfg_time;
          slot_en[i]   <= cfg_en;
        end
      end
    end
  end

  // Slot matches, lowest-index selection and the written-slot mask.
  always_comb begin
    match_vec = '0;
    cfg_mask  = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      match_vec[i] = min_tick && slot_en[i] && (slot_time[i] == time_now);
      cfg_mask[i]  = (cfg_slot == 3'(i));
    end
    pend_eff = pending | match_vec;
    sel      = 3'd0;
    sel_mask = '0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (pend_eff[i]) begin
        sel         = 3'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  assign taken_rise_c = taken && !taken_prev;
  assign wm_inc       = wait_min + {5'd0, min_tick};
  assign serving_c    = (state == REMIND) || (state == ALARM);

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    pending_n   = pend_eff;
    active_n    = active_slot;
    wait_n      = wait_min;
    miss_n      = miss_count;
    dose_ok_n   = 1'b0;
    dose_miss_n = 1'b0;
    beep_cnt_n  = '0;
    buzzer_n    = 1'b0;

    case (state)
      IDLE: begin
        if (|pend_eff) begin
          state_n   = REMIND;
          active_n  = sel;
          wait_n    = 6'd0;
          pending_n = pend_eff & ~sel_mask;
        end
      end
      REMIND: begin
        wait_n = wm_inc;
        if (taken_rise_c) begin
          state_n   = DONE;
          dose_ok_n = 1'b1;
        end else if (wm_inc == 6'(WARN_MIN)) begin
          state_n = ALARM;
        end
      end
      ALARM: begin
        wait_n = wm_inc;
        if (taken_rise_c) begin
          state_n   = DONE;
          dose_ok_n = 1'b1;
        end else if (wm_inc == 6'(GRACE_MIN)) begin
          state_n     = DONE;
          dose_miss_n = 1'b1;
          miss_n      = (&miss_count) ? miss_count : miss_count + MISS_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Reprogramming the served slot drops any re-queued match for it.
    if (cfg_accept_c && serving_c && (cfg_slot == active_slot)) begin
      pending_n = pending_n & ~cfg_mask;
    end

    its_time_n = (state_n == REMIND) || (state_n == ALARM);
    alarm_n    = (state_n == ALARM);

    // Buzzer: restarts low on REMIND entry, toggles every BEEP_DIV cycles.
    if (state_n == ALARM) begin
      buzzer_n = 1'b1;
    end else if ((state_n == REMIND) && (state == REMIND)) begin
      if (beep_cnt == BEEP_W'(BEEP_DIV - 1)) begin
        beep_cnt_n = '0;
        buzzer_n   = !buzzer;
      end else begin
        beep_cnt_n = beep_cnt + BEEP_W'(1);
        buzzer_n   = buzzer;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      time_prev   <= time_now;
      min_tick    <= 1'b0;
      taken_prev  <= 1'b0;
      beep_cnt    <= '0;
      pending     <= '0;
      active_slot <= 3'd0;
      wait_min    <= 6'd0;
      miss_count  <= '0;
      its_time    <= 1'b0;
      alarm       <= 1'b0;
      buzzer      <= 1'b0;
      dose_ok     <= 1'b0;
      dose_miss   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_n;
      time_prev   <= time_now;
      min_tick    <= (time_now != time_prev);
      taken_prev  <= taken;
      beep_cnt    <= beep_cnt_n;
      pending     <= pending_n;
      active_slot <= active_n;
      wait_min    <= wait_n;
      miss_count  <= miss_n;
      its_time    <= its_time_n;
      alarm       <= alarm_n;
      buzzer      <= buzzer_n;
      dose_ok     <= dose_ok_n;
      dose_miss   <= dose_miss_n;
      cfg_err     <= cfg_we && !cfg_accept_c;
    end
  end

endmodule

// File: tb/tb_pill_multi_slot_scheduler.sv
// Directed bench for pill_multi_slot_scheduler (BEEP_DIV shortened to 4 cycles).
module tb_pill_multi_slot_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] time_now;
  logic        cfg_we;
  logic [2:0]  cfg_slot;
  logic [15:0] cfg_time;
  logic        cfg_en;
  logic        taken;
  logic        its_time, alarm, buzzer, dose_ok, dose_miss, cfg_err;
  logic [2:0]  active_slot;
  logic [5:0]  wait_min;
  logic [3:0]  pending;
  logic [3:0]  miss_count;

  int total = 0;
  int bad   = 0;

  pill_multi_slot_scheduler #(
    .N_SLOTS(4), .WARN_MIN(5), .GRACE_MIN(30), .BEEP_DIV(4), .MISS_W(4)
  ) dut (
    .clk(clk), .reset(reset), .time_now(time_now),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_time(cfg_time), .cfg_en(cfg_en),
    .taken(taken), .its_time(its_time), .alarm(alarm), .buzzer(buzzer),
    .active_slot(active_slot), .wait_min(wait_min), .pending(pending),
    .miss_count(miss_count), .dose_ok(dose_ok), .dose_miss(dose_miss),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] s, input logic [15:0] t, input logic en);
    cfg_we = 1'b1; cfg_slot = s; cfg_time = t; cfg_en = en;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_taken();
    taken = 1'b1;
    step(1);
    taken = 1'b0;
  endtask

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = t;
    if (m0 != 4'd9) m0 = m0 + 4'd1;
    else begin
      m0 = 4'd0;
      if (m1 != 4'd5) m1 = m1 + 4'd1;
      else begin
        m1 = 4'd0;
        if (h1 == 4'd2 && h0 == 4'd3) begin h1 = 4'd0; h0 = 4'd0; end
        else if (h0 == 4'd9) begin h0 = 4'd0; h1 = h1 + 4'd1; end
        else h0 = h0 + 4'd1;
      end
    end
    return {h1, h0, m1, m0};
  endfunction

  initial begin
    logic [15:0] t;
    reset = 1'b1; time_now = 16'h1829; cfg_we = 1'b0; cfg_slot = 3'd0;
    cfg_time = 16'h0000; cfg_en = 1'b0; taken = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_its_time", its_time, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_active", active_slot, 0);
    chk("rst_wait", wait_min, 0);
    chk("rst_pending", pending, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_pulses", {dose_ok, dose_miss, cfg_err}, 0);

    // 1: single slot, taken after 100 cycles
    cfg(3'd0, 16'h1830, 1'b1);
    chk("t1_cfg_ok", cfg_err, 0);
    time_now = 16'h1830;
    step(1);
    chk("t1_its_lat1", its_time, 0);
    step(1);
    chk("t1_its_lat2", its_time, 1);
    chk("t1_active", active_slot, 0);
    chk("t1_pending", pending, 0);
    chk("t1_buz_start", buzzer, 0);
    step(3);
    chk("t1_buz_hold", buzzer, 0);
    step(1);
    chk("t1_buz_tog1", buzzer, 1);
    step(4);
    chk("t1_buz_tog2", buzzer, 0);
    step(90);
    pulse_taken();
    chk("t1_dose_ok", dose_ok, 1);
    chk("t1_done_its", its_time, 0);
    chk("t1_miss", miss_count, 0);
    step(1);
    chk("t1_ok_pulse", dose_ok, 0);

    // taken edge while idle is ignored
    pulse_taken();
    chk("idle_taken", {dose_ok, its_time}, 0);

    // 2: no taken -> escalation then miss
    cfg(3'd1, 16'h0800, 1'b1);
    time_now = 16'h0759; step(3);
    time_now = 16'h0800; step(2);
    chk("t2_its", its_time, 1);
    chk("t2_active", active_slot, 1);
    t = 16'h0800;
    for (int i = 1; i <= 30; i++) begin
      t = bcd_inc(t);
      time_now = t;
      step(2);
      if (i == 4) begin
        chk("t2_noalarm4", alarm, 0);
        chk("t2_wait4", wait_min, 4);
      end
      if (i == 5) begin
        chk("t2_alarm5", alarm, 1);
        chk("t2_wait5", wait_min, 5);
        chk("t2_buz_alarm", buzzer, 1);
      end
      if (i == 29) chk("t2_nomiss29", dose_miss, 0);
      if (i == 30) begin
        chk("t2_miss30", dose_miss, 1);
        chk("t2_misscnt", miss_count, 1);
        chk("t2_its_off", {its_time, alarm, buzzer}, 0);
      end
      step(1);
    end
    chk("t2_miss_pulse", dose_miss, 0);

    // 3: two slots same time -> lowest first, other queued
    cfg(3'd2, 16'h1200, 1'b1);
    cfg(3'd0, 16'h1200, 1'b1);
    time_now = 16'h1159; step(3);
    time_now = 16'h1200; step(2);
    chk("t3_active0", active_slot, 0);
    chk("t3_pending", pending, 4'b0100);
    pulse_taken();
    chk("t3_ok0", dose_ok, 1);
    step(2);
    chk("t3_its2", its_time, 1);
    chk("t3_active2", active_slot, 2);
    chk("t3_pending0", pending, 0);
    pulse_taken();
    chk("t3_ok2", dose_ok, 1);
    step(2);

    // 4: rejected config writes
    cfg(3'd1, 16'h2460, 1'b1);
    chk("t4_err_time", cfg_err, 1);
    step(1);
    chk("t4_err_clr", cfg_err, 0);
    cfg(3'd5, 16'h0900, 1'b1);
    chk("t4_err_slot", cfg_err, 1);
    cfg(3'd1, 16'h1960, 1'b1);
    chk("t4_err_min", cfg_err, 1);
    time_now = 16'h0759; step(3);
    time_now = 16'h0800; step(2);
    chk("t4_slot1_kept", {its_time, active_slot}, {1'b1, 3'd1});
    pulse_taken();
    step(2);
    time_now = 16'h0859; step(3);
    time_now = 16'h0900; step(2);
    chk("t4_no_alias", its_time, 0);

    // 5: midnight wrap then reset mid-REMIND
    cfg(3'd3, 16'h0000, 1'b1);
    cfg(3'd2, 16'h0000, 1'b1);
    time_now = 16'h2359; step(3);
    time_now = 16'h0000; step(2);
    chk("t5_its", its_time, 1);
    chk("t5_active", active_slot, 2);
    chk("t5_pending", pending, 4'b1000);
    reset = 1'b1;
    step(1);
    chk("t5_rst_its", its_time, 0);
    chk("t5_rst_pending", pending, 0);
    chk("t5_rst_miss", miss_count, 0);
    reset = 1'b0;
    step(2);
    chk("t5_idle", its_time, 0);

    // 6: sixteen misses saturate the counter
    t = 16'h0000;
    for (int d = 0; d < 16; d++) begin
      t = bcd_inc(t);
      cfg(3'd0, t, 1'b1);
      time_now = t;
      step(2);
      for (int k = 0; k < 30; k++) begin
        t = bcd_inc(t);
        time_now = t;
        step(3);
      end
      step(2);
      chk("t6_miss_count", miss_count, (d < 15) ? d + 1 : 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
